m216a_slot_scheduler: RTL and testbench

- Front-end controller for the sticker-placement core (M216A_TopModule datapath).
- The core takes one height/width pair per fixed 4-cycle slot and returns index_x/index_y a fixed number of slots later.
- This block arbitrates two requesters round-robin into that slot cadence, feeds the core (zeros on idle slots), filters zero-dimension requests, and routes each result back with its source ID.

---
 rtl/m216a_slot_scheduler.sv | 155 +++++++++++++++
 tb/tb_m216a_slot_scheduler.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/m216a_slot_scheduler.sv
// m216a_slot_scheduler
// Front-end slot scheduler for the sticker-placement core. Two requesters are
// arbitrated round-robin into fixed SLOT_CYCLES-cycle core slots; zero-size
// requests are accepted but filtered (and counted), and each core result is
// routed back CORE_LAT_SLOTS slots later tagged with its requester ID.
//
// Ports:
//   clk_i, rst_i              clock (rising edge), synchronous active-low reset
//   reqN_valid_i/ready_o      requester N handshake (ready only at last phase)
//   reqN_height_i/width_i     requester N sticker dimensions
//   core_height_o/width_o     dimensions to the core, held for one slot
//   core_start_o              pulse at phase 0 of a dispatched slot
//   core_index_x_i/y_i        core result
//   rsp_valid_o/src_o         response strobe and requester ID
//   rsp_index_x_o/y_o         registered result, held until the next response
//   phase_o                   current slot phase
//   drop_cnt_o                saturating count of zero-dimension requests
module m216a_slot_scheduler #(
  parameter int unsigned SLOT_CYCLES    = 4,
  parameter int unsigned CORE_LAT_SLOTS = 2,
  parameter int unsigned DROP_W         = 8
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           req0_valid_i,
  output logic                           req0_ready_o,
  input  logic [4:0]                     req0_height_i,
  input  logic [4:0]                     req0_width_i,
  input  logic                           req1_valid_i,
  output logic                           req1_ready_o,
  input  logic [4:0]                     req1_height_i,
  input  logic [4:0]                     req1_width_i,
  output logic [4:0]                     core_height_o,
  output logic [4:0]                     core_width_o,
  output logic                           core_start_o,
  input  logic [7:0]                     core_index_x_i,
  input  logic [7:0]                     core_index_y_i,
  output logic                           rsp_valid_o,
  output logic                           rsp_src_o,
  output logic [7:0]                     rsp_index_x_o,
  output logic [7:0]                     rsp_index_y_o,
  output logic [$clog2(SLOT_CYCLES)-1:0] phase_o,
  output logic [DROP_W-1:0]              drop_cnt_o
);

  localparam int unsigned PW = $clog2(SLOT_CYCLES);
  localparam logic [PW-1:0] LAST_PHASE = PW'(SLOT_CYCLES - 1);
  localparam logic [DROP_W-1:0] DROP_MAX = {DROP_W{1'b1}};

  // Tag entry: bit 1 = result expected, bit 0 = requester ID
  logic [PW-1:0]                 phase_q, phase_d;
  logic                          last_grant_q, last_grant_d;
  logic [CORE_LAT_SLOTS:0][1:0]  tag_q, tag_d;
  logic [4:0]                    core_h_q, core_h_d, core_w_q, core_w_d;
  logic                          core_start_q, core_start_d;
  logic                          rsp_valid_q, rsp_valid_d;
  logic                          rsp_src_q, rsp_src_d;
  logic [7:0]                    rsp_x_q, rsp_x_d, rsp_y_q, rsp_y_d;
  logic [DROP_W-1:0]             drop_q, drop_d;

  logic       at_end, grant0, grant1, hs, sel_src, nonzero;
  logic [4:0] sel_h, sel_w;

  // Round-robin grant and handshake decode; ready only in the last phase
  always_comb begin
    at_end       = (phase_q == LAST_PHASE);
    grant0       = req0_valid_i && (!req1_valid_i || last_grant_q);
    grant1       = req1_valid_i && (!req0_valid_i || !last_grant_q);
    req0_ready_o = rst_i && at_end && grant0;
    req1_ready_o = rst_i && at_end && grant1;
    hs           = (req0_ready_o && req0_valid_i) || (req1_ready_o && req1_valid_i);
    sel_src      = req1_ready_o;
    sel_h        = sel_src ? req1_height_i : req0_height_i;
    sel_w        = sel_src ? req1_width_i  : req0_width_i;
    nonzero      = (sel_h != 5'd0) && (sel_w != 5'd0);
  end

  // Next-state: everything slot-related updates at the edge entering phase 0
  always_comb begin
    phase_d      = phase_q + PW'(1);
    last_grant_d = last_grant_q;
    tag_d        = tag_q;
    core_h_d     = core_h_q;
    core_w_d     = core_w_q;
    core_start_d = 1'b0;
    rsp_valid_d  = 1'b0;
    rsp_src_d    = rsp_src_q;
    rsp_x_d      = rsp_x_q;
    rsp_y_d      = rsp_y_q;
    drop_d       = drop_q;

    if (at_end) begin
      if (hs) begin
        last_grant_d = sel_src;
      end
      core_h_d     = (hs && nonzero) ? sel_h : 5'd0;
      core_w_d     = (hs && nonzero) ? sel_w : 5'd0;
      core_start_d = hs && nonzero;
      if (hs && !nonzero && (drop_q != DROP_MAX)) begin
        drop_d = drop_q + DROP_W'(1);
      end
      // Oldest tag lines up with the core result presented this phase
      if (tag_q[CORE_LAT_SLOTS][1]) begin
        rsp_valid_d = 1'b1;
        rsp_src_d   = tag_q[CORE_LAT_SLOTS][0];
        rsp_x_d     = core_index_x_i;
        rsp_y_d     = core_index_y_i;
      end
      for (int unsigned i = CORE_LAT_SLOTS; i > 0; i--) begin
        tag_d[i] = tag_q[i-1];
      end
      tag_d[0] = {hs && nonzero, sel_src};
    end
  end

  // State registers
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      phase_q      <= '0;
      last_grant_q <= 1'b1;
      tag_q        <= '0;
      core_h_q     <= '0;
      core_w_q     <= '0;
      core_start_q <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_src_q    <= 1'b0;
      rsp_x_q      <= '0;
      rsp_y_q      <= '0;
      drop_q       <= '0;
    end else begin
      phase_q      <= phase_d;
      last_grant_q <= last_grant_d;
      tag_q        <= tag_d;
      core_h_q     <= core_h_d;
      core_w_q     <= core_w_d;
      core_start_q <= core_start_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_src_q    <= rsp_src_d;
      rsp_x_q      <= rsp_x_d;
      rsp_y_q      <= rsp_y_d;
      drop_q       <= drop_d;
    end
  end

  assign core_height_o = core_h_q;
  assign core_width_o  = core_w_q;
  assign core_start_o  = core_start_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_src_o     = rsp_src_q;
  assign rsp_index_x_o = rsp_x_q;
  assign rsp_index_y_o = rsp_y_q;
  assign phase_o       = phase_q;
  assign drop_cnt_o    = drop_q;

endmodule

// File: tb/tb_m216a_slot_scheduler.sv
// Testbench for m216a_slot_scheduler: directed scenarios plus random traffic,
// compared against a slot-level reference model with a response scoreboard.
module tb_m216a_slot_scheduler;

  localparam int S   = 4;
  localparam int L   = 2;
  localparam int LAT = (L + 1) * S;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       req0_valid_i, req0_ready_o, req1_valid_i, req1_ready_o;
  logic [4:0] req0_height_i, req0_width_i, req1_height_i, req1_width_i;
  logic [4:0] core_height_o, core_width_o;
  logic       core_start_o;
  logic [7:0] core_index_x_i, core_index_y_i;
  logic       rsp_valid_o, rsp_src_o;
  logic [7:0] rsp_index_x_o, rsp_index_y_o;
  logic [1:0] phase_o;
  logic [7:0] drop_cnt_o;

  m216a_slot_scheduler #(.SLOT_CYCLES(S), .CORE_LAT_SLOTS(L), .DROP_W(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o),
    .req0_height_i(req0_height_i), .req0_width_i(req0_width_i),
    .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o),
    .req1_height_i(req1_height_i), .req1_width_i(req1_width_i),
    .core_height_o(core_height_o), .core_width_o(core_width_o),
    .core_start_o(core_start_o),
    .core_index_x_i(core_index_x_i), .core_index_y_i(core_index_y_i),
    .rsp_valid_o(rsp_valid_o), .rsp_src_o(rsp_src_o),
    .rsp_index_x_o(rsp_index_x_o), .rsp_index_y_o(rsp_index_y_o),
    .phase_o(phase_o), .drop_cnt_o(drop_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int src;
    int x;
    int y;
    int due;
  } exp_t;

  exp_t expq[$];
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;
  bit   armed = 1'b0;

  // Reference model state
  int m_phase = 0, m_last = 1, m_h = 0, m_w = 0, m_start = 0, m_drop = 0;
  int m_rsrc = 0, m_rx = 0, m_ry = 0;
  int g, hh, ww;
  bit pend_v[64];
  int pend_x[64], pend_y[64];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model: one decision per slot boundary from the arbitration rules
  always @(posedge clk_i) begin
    cyc++;
    if (!rst_i) begin
      armed   = 1'b1;
      m_phase = 0; m_last = 1; m_h = 0; m_w = 0; m_start = 0; m_drop = 0;
      m_rsrc  = 0; m_rx = 0; m_ry = 0;
      expq.delete();
      for (int i = 0; i < 64; i++) pend_v[i] = 1'b0;
    end else begin
      m_start = 0;
      if (m_phase == S - 1) begin
        g = -1;
        if (req0_valid_i && req1_valid_i) g = (m_last == 1) ? 0 : 1;
        else if (req0_valid_i) g = 0;
        else if (req1_valid_i) g = 1;
        m_h = 0; m_w = 0;
        if (g >= 0) begin
          hh = (g == 1) ? int'(req1_height_i) : int'(req0_height_i);
          ww = (g == 1) ? int'(req1_width_i)  : int'(req0_width_i);
          m_last = g;
          if (hh != 0 && ww != 0) begin
            exp_t e;
            m_h = hh; m_w = ww; m_start = 1;
            e.src = g;
            e.x   = int'($urandom_range(0, 255));
            e.y   = int'($urandom_range(0, 255));
            e.due = cyc + LAT;
            expq.push_back(e);
            pend_v[(cyc + LAT) % 64] = 1'b1;
            pend_x[(cyc + LAT) % 64] = e.x;
            pend_y[(cyc + LAT) % 64] = e.y;
          end else if (m_drop < 255) begin
            m_drop++;
          end
        end
      end
      m_phase = (m_phase + 1) % S;
    end
  end

  // Stand-in core: presents the scoreboarded result exactly on its capture edge
  always @(posedge clk_i) begin
    #1;
    if (pend_v[(cyc + 1) % 64]) begin
      core_index_x_i = 8'(pend_x[(cyc + 1) % 64]);
      core_index_y_i = 8'(pend_y[(cyc + 1) % 64]);
      pend_v[(cyc + 1) % 64] = 1'b0;
    end else begin
      core_index_x_i = 8'($urandom);
      core_index_y_i = 8'($urandom);
    end
  end

  // Monitor: compare DUT outputs against model, pop scoreboard on responses
  always @(negedge clk_i) begin
    if (armed) begin
      check("ready0", int'(req0_ready_o),
            int'(rst_i && m_phase == S - 1 && req0_valid_i && (!req1_valid_i || m_last == 1)));
      check("ready1", int'(req1_ready_o),
            int'(rst_i && m_phase == S - 1 && req1_valid_i && (!req0_valid_i || m_last == 0)));
      check("phase", int'(phase_o), m_phase);
      check("core_h", int'(core_height_o), m_h);
      check("core_w", int'(core_width_o), m_w);
      check("core_start", int'(core_start_o), m_start);
      check("drop_cnt", int'(drop_cnt_o), m_drop);
      if (rsp_valid_o) begin
        if (expq.size() == 0) begin
          check("rsp_unexpected", 1, 0);
        end else begin
          exp_t e;
          e = expq.pop_front();
          check("rsp_time", cyc, e.due);
          m_rsrc = e.src; m_rx = e.x; m_ry = e.y;
        end
      end else if (expq.size() > 0 && expq[0].due <= cyc) begin
        check("rsp_missing", 0, 1);
        void'(expq.pop_front());
      end
      check("rsp_src", int'(rsp_src_o), m_rsrc);
      check("rsp_x", int'(rsp_index_x_o), m_rx);
      check("rsp_y", int'(rsp_index_y_o), m_ry);
    end
  end

  task automatic send(input int p, input int h, input int w);
    bit hs = 1'b0;
    if (p == 0) begin
      req0_valid_i = 1'b1; req0_height_i = 5'(h); req0_width_i = 5'(w);
    end else begin
      req1_valid_i = 1'b1; req1_height_i = 5'(h); req1_width_i = 5'(w);
    end
    for (int i = 0; i < 16; i++) begin
      @(negedge clk_i);
      if ((p == 0 && req0_ready_o) || (p == 1 && req1_ready_o)) begin
        hs = 1'b1;
        break;
      end
    end
    @(posedge clk_i); #1;
    if (p == 0) req0_valid_i = 1'b0; else req1_valid_i = 1'b0;
    if (!hs) check("send_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_i = 1'b0;
    req0_valid_i = 1'b0; req0_height_i = '0; req0_width_i = '0;
    req1_valid_i = 1'b0; req1_height_i = '0; req1_width_i = '0;
    core_index_x_i = '0; core_index_y_i = '0;
    idle(3);
    rst_i = 1'b1;

    // Single request
    send(0, 3, 5);
    idle(16);

    // Both requesters contending for 6 slots
    req0_valid_i = 1'b1; req0_height_i = 5'd2; req0_width_i = 5'd4;
    req1_valid_i = 1'b1; req1_height_i = 5'd6; req1_width_i = 5'd7;
    idle(24);
    req0_valid_i = 1'b0; req1_valid_i = 1'b0;
    idle(16);

    // Zero-width request then a normal one
    send(1, 4, 0);
    send(0, 3, 3);
    idle(20);

    // Two in flight, then reset mid-slot
    send(0, 1, 2);
    send(1, 3, 4);
    idle(2);
    rst_i = 1'b0;
    idle(3);
    rst_i = 1'b1;
    send(0, 5, 5);
    idle(20);

    // Random traffic with occasional short resets
    for (int i = 0; i < 600; i++) begin
      req0_valid_i  = ($urandom_range(0, 99) < 60);
      req1_valid_i  = ($urandom_range(0, 99) < 60);
      req0_height_i = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom);
      req0_width_i  = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom);
      req1_height_i = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom);
      req1_width_i  = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom);
      rst_i = ($urandom_range(0, 199) != 0);
      idle(1);
    end
    rst_i = 1'b1;
    req0_valid_i = 1'b0; req1_valid_i = 1'b0;
    idle(20);

    // Saturate the drop counter with back-to-back zero-width requests
    req0_valid_i = 1'b1; req0_height_i = 5'd7; req0_width_i = 5'd0;
    idle(300 * S + 8);
    req0_valid_i = 1'b0;
    @(negedge clk_i);
    check("drop_saturated", int'(drop_cnt_o), 255);
    idle(20);

    check("scoreboard_drained", expq.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
